// File: rtl/sal_sched_rr.sv
// DRAM command scheduler: fixed class priority ACT>RD>WR>PRE>REF, round-robin within a class,
// inter-bank timing counters and a registered command output. Define SAL_SCHED_FAW_EN for the tFAW window limit.
module sal_sched_rr #(
  parameter int BK_CNT = 16,
  parameter int RA_W   = 16,
  parameter int CA_W   = 10,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4,
  parameter int TW     = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BK_CNT-1:0]          act_req_i,
  input  logic [BK_CNT-1:0]          rd_req_i,
  input  logic [BK_CNT-1:0]          wr_req_i,
  input  logic [BK_CNT-1:0]          pre_req_i,
  input  logic [BK_CNT-1:0]          ref_req_i,
  input  logic [BK_CNT*RA_W-1:0]     ra_i,
  input  logic [BK_CNT*CA_W-1:0]     ca_i,
  input  logic [BK_CNT*ID_W-1:0]     id_i,
  input  logic [BK_CNT*LEN_W-1:0]    len_i,
  output logic [BK_CNT-1:0]          act_gnt_o,
  output logic [BK_CNT-1:0]          rd_gnt_o,
  output logic [BK_CNT-1:0]          wr_gnt_o,
  output logic [BK_CNT-1:0]          pre_gnt_o,
  output logic [BK_CNT-1:0]          ref_gnt_o,
  input  logic [TW-1:0]              t_rrd_m1_i,
  input  logic [TW-1:0]              t_ccd_m1_i,
  input  logic [TW-1:0]              t_rtw_m1_i,
  input  logic [TW-1:0]              t_wtr_m1_i,
  input  logic [TW-1:0]              t_faw_m1_i,
  output logic                       cmd_valid_o,
  output logic [2:0]                 cmd_type_o,
  output logic [$clog2(BK_CNT)-1:0]  cmd_ba_o,
  output logic [RA_W-1:0]            cmd_ra_o,
  output logic [CA_W-1:0]            cmd_ca_o,
  output logic [ID_W-1:0]            cmd_id_o,
  output logic [LEN_W-1:0]           cmd_len_o
);

  localparam int BW   = $clog2(BK_CNT);
  localparam int NCLS = 5;
  localparam logic [2:0] CLS_ACT = 3'd0;
  localparam logic [2:0] CLS_RD  = 3'd1;
  localparam logic [2:0] CLS_WR  = 3'd2;

  logic [BK_CNT-1:0] req  [NCLS];
  logic [BK_CNT-1:0] gnt  [NCLS];
  logic [BW-1:0]     ptr  [NCLS];
  logic [BW:0]       pick [NCLS];
  logic [NCLS-1:0]   elig;
  logic              win_vld;
  logic              fire;
  logic [2:0]        win_cls;
  logic [BW-1:0]     win_bank;
  logic              act_fire, rd_fire, wr_fire;
  logic [TW-1:0]     rrd_cnt, ccd_cnt, rtw_cnt, wtr_cnt;
  logic              rrd_met, ccd_met, rtw_met, wtr_met;
  logic              faw_ok;

  assign req[0] = act_req_i;
  assign req[1] = rd_req_i;
  assign req[2] = wr_req_i;
  assign req[3] = pre_req_i;
  assign req[4] = ref_req_i;

  // Returns {found, bank} of the first requester at or after ptr, wrapping mod BK_CNT.
  function automatic logic [BW:0] rr_pick(input logic [BK_CNT-1:0] r, input logic [BW-1:0] p);
    logic [BW:0]   res;
    logic [BW-1:0] bidx;
    int            idx;
    res = '0;
    for (int i = BK_CNT - 1; i >= 0; i--) begin
      idx = int'(p) + i;
      if (idx >= BK_CNT) idx = idx - BK_CNT;
      bidx = BW'(idx);
      if (r[bidx]) res = {1'b1, bidx};
    end
    return res;
  endfunction

  function automatic logic [TW-1:0] tick(input logic [TW-1:0] cnt, input logic trig,
                                         input logic [TW-1:0] m1);
    if (trig) return m1;
    if (cnt != '0) return cnt - TW'(1);
    return cnt;
  endfunction

  always_comb begin
    for (int c = 0; c < NCLS; c++) pick[c] = rr_pick(req[c], ptr[c]);
  end

  assign rrd_met = (rrd_cnt == '0);
  assign ccd_met = (ccd_cnt == '0);
  assign rtw_met = (rtw_cnt == '0);
  assign wtr_met = (wtr_cnt == '0);

  assign elig[0] = pick[0][BW] & rrd_met & faw_ok;
  assign elig[1] = pick[1][BW] & ccd_met & wtr_met;
  assign elig[2] = pick[2][BW] & ccd_met & rtw_met;
  assign elig[3] = pick[3][BW];
  assign elig[4] = pick[4][BW] & rrd_met;

  // Descending scan so the highest-priority (lowest index) eligible class is written last.
  always_comb begin
    win_vld  = 1'b0;
    win_cls  = CLS_ACT;
    win_bank = '0;
    for (int c = NCLS - 1; c >= 0; c--) begin
      if (elig[c]) begin
        win_vld  = 1'b1;
        win_cls  = 3'(c);
        win_bank = pick[c][BW-1:0];
      end
    end
    fire = win_vld & ~rst;
    for (int c = 0; c < NCLS; c++) begin
      gnt[c] = (fire && win_cls == 3'(c)) ? (BK_CNT'(1) << win_bank) : '0;
    end
  end

  assign act_gnt_o = gnt[0];
  assign rd_gnt_o  = gnt[1];
  assign wr_gnt_o  = gnt[2];
  assign pre_gnt_o = gnt[3];
  assign ref_gnt_o = gnt[4];

  assign act_fire = fire && win_cls == CLS_ACT;
  assign rd_fire  = fire && win_cls == CLS_RD;
  assign wr_fire  = fire && win_cls == CLS_WR;

  always_ff @(posedge clk) begin
    if (rst) begin
      rrd_cnt <= '0;
      ccd_cnt <= '0;
      rtw_cnt <= '0;
      wtr_cnt <= '0;
      for (int c = 0; c < NCLS; c++) ptr[c] <= '0;
    end else begin
      rrd_cnt <= tick(rrd_cnt, act_fire, t_rrd_m1_i);
      ccd_cnt <= tick(ccd_cnt, rd_fire | wr_fire, t_ccd_m1_i);
      rtw_cnt <= tick(rtw_cnt, rd_fire, t_rtw_m1_i);
      wtr_cnt <= tick(wtr_cnt, wr_fire, t_wtr_m1_i);
      for (int c = 0; c < NCLS; c++) begin
        if (fire && win_cls == 3'(c)) begin
          ptr[c] <= (win_bank == BW'(BK_CNT - 1)) ? '0 : win_bank + BW'(1);
        end
      end
    end
  end

`ifdef SAL_SCHED_FAW_EN
  logic [TW-1:0] faw_cnt [4];
  logic [1:0]    faw_sel;

  // Lowest-index idle window slot takes the next ACT.
  always_comb begin
    faw_ok  = 1'b0;
    faw_sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (faw_cnt[i] == '0) begin
        faw_ok  = 1'b1;
        faw_sel = 2'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) faw_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        faw_cnt[i] <= tick(faw_cnt[i], act_fire && faw_sel == 2'(i), t_faw_m1_i);
      end
    end
  end
`else
  logic unused_faw;
  assign unused_faw = ^t_faw_m1_i;
  assign faw_ok     = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid_o <= 1'b0;
      cmd_type_o  <= '0;
      cmd_ba_o    <= '0;
      cmd_ra_o    <= '0;
      cmd_ca_o    <= '0;
      cmd_id_o    <= '0;
      cmd_len_o   <= '0;
    end else if (fire) begin
      cmd_valid_o <= 1'b1;
      cmd_type_o  <= win_cls;
      cmd_ba_o    <= win_bank;
      cmd_ra_o    <= act_fire ? ra_i[int'(win_bank)*RA_W +: RA_W] : '0;
      cmd_ca_o    <= (rd_fire | wr_fire) ? ca_i[int'(win_bank)*CA_W +: CA_W] : '0;
      cmd_id_o    <= (rd_fire | wr_fire) ? id_i[int'(win_bank)*ID_W +: ID_W] : '0;
      cmd_len_o   <= (rd_fire | wr_fire) ? len_i[int'(win_bank)*LEN_W +: LEN_W] : '0;
    end else begin
      cmd_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sal_sched_rr.sv
// Bench for sal_sched_rr: directed scenarios plus randomized traffic against a time-stamp based reference model.
module tb_sal_sched_rr;
  localparam int N = 4, RA_W = 16, CA_W = 10, ID_W = 4, LEN_W = 4, TW = 5;
  localparam int BW = $clog2(N);

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] act_req, rd_req, wr_req, pre_req, ref_req;
  logic [N*RA_W-1:0] ra;
  logic [N*CA_W-1:0] ca;
  logic [N*ID_W-1:0] id;
  logic [N*LEN_W-1:0] len;
  logic [N-1:0] act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o;
  logic [TW-1:0] t_rrd, t_ccd, t_rtw, t_wtr, t_faw;
  logic cmd_valid_o;
  logic [2:0] cmd_type_o;
  logic [BW-1:0] cmd_ba_o;
  logic [RA_W-1:0] cmd_ra_o;
  logic [CA_W-1:0] cmd_ca_o;
  logic [ID_W-1:0] cmd_id_o;
  logic [LEN_W-1:0] cmd_len_o;

  int checks = 0, failures = 0;
  int cyc, obs_cls, obs_bank;
  int ptr_m [5];
  int last_act, last_cas, last_rd, last_wr;
  int act_times [$];
  logic e_valid;
  logic [2:0] e_type;
  logic [BW-1:0] e_ba;
  logic [RA_W-1:0] e_ra;
  logic [CA_W-1:0] e_ca;
  logic [ID_W-1:0] e_id;
  logic [LEN_W-1:0] e_len;

  sal_sched_rr #(.BK_CNT(N), .RA_W(RA_W), .CA_W(CA_W), .ID_W(ID_W), .LEN_W(LEN_W), .TW(TW)) dut (
    .clk(clk), .rst(rst),
    .act_req_i(act_req), .rd_req_i(rd_req), .wr_req_i(wr_req), .pre_req_i(pre_req), .ref_req_i(ref_req),
    .ra_i(ra), .ca_i(ca), .id_i(id), .len_i(len),
    .act_gnt_o(act_gnt_o), .rd_gnt_o(rd_gnt_o), .wr_gnt_o(wr_gnt_o), .pre_gnt_o(pre_gnt_o), .ref_gnt_o(ref_gnt_o),
    .t_rrd_m1_i(t_rrd), .t_ccd_m1_i(t_ccd), .t_rtw_m1_i(t_rtw), .t_wtr_m1_i(t_wtr), .t_faw_m1_i(t_faw),
    .cmd_valid_o(cmd_valid_o), .cmd_type_o(cmd_type_o), .cmd_ba_o(cmd_ba_o), .cmd_ra_o(cmd_ra_o),
    .cmd_ca_o(cmd_ca_o), .cmd_id_o(cmd_id_o), .cmd_len_o(cmd_len_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    for (int c = 0; c < 5; c++) ptr_m[c] = 0;
    last_act = -1000; last_cas = -1000; last_rd = -1000; last_wr = -1000;
    act_times.delete();
    e_valid = 0; e_type = '0; e_ba = '0; e_ra = '0; e_ca = '0; e_id = '0; e_len = '0;
  endtask

  // A command spaced by m1 after its trigger is legal once more than m1 cycles have elapsed.
  function automatic bit faw_ok_m();
`ifdef SAL_SCHED_FAW_EN
    int n = 0;
    foreach (act_times[i]) if (cyc - act_times[i] <= int'(t_faw)) n++;
    return n < 4;
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit elig(int c);
    bit rrd_ok = (cyc - last_act) > int'(t_rrd);
    bit ccd_ok = (cyc - last_cas) > int'(t_ccd);
    bit wtr_ok = (cyc - last_wr) > int'(t_wtr);
    bit rtw_ok = (cyc - last_rd) > int'(t_rtw);
    case (c)
      0: return rrd_ok && faw_ok_m();
      1: return ccd_ok && wtr_ok;
      2: return ccd_ok && rtw_ok;
      3: return 1'b1;
      default: return rrd_ok;
    endcase
  endfunction

  // One clock cycle: drive data, check grants and the output register at negedge, advance the model.
  task automatic step();
    logic [N-1:0] rq [5];
    logic [N-1:0] eg [5];
    logic [N-1:0] og [5];
    int wc, wb, k;
    for (int b = 0; b < N; b++) begin
      ra[b*RA_W +: RA_W] = RA_W'($urandom);
      ca[b*CA_W +: CA_W] = CA_W'($urandom);
      id[b*ID_W +: ID_W] = ID_W'($urandom);
      len[b*LEN_W +: LEN_W] = LEN_W'($urandom);
    end
    @(negedge clk);
    rq[0] = act_req; rq[1] = rd_req; rq[2] = wr_req; rq[3] = pre_req; rq[4] = ref_req;
    og[0] = act_gnt_o; og[1] = rd_gnt_o; og[2] = wr_gnt_o; og[3] = pre_gnt_o; og[4] = ref_gnt_o;
    wc = -1; wb = -1;
    if (!rst) begin
      for (int c = 0; c < 5; c++) begin
        if (wc < 0 && rq[c] != '0 && elig(c)) begin
          wc = c;
          for (int i = 0; i < N; i++) begin
            k = (ptr_m[c] + i) % N;
            if (wb < 0 && rq[c][BW'(k)]) wb = k;
          end
        end
      end
    end
    for (int c = 0; c < 5; c++) eg[c] = (c == wc) ? (N'(1) << wb) : '0;
    obs_cls = -1; obs_bank = -1;
    for (int c = 0; c < 5; c++)
      for (int b = 0; b < N; b++)
        if (og[c][b] === 1'b1) begin obs_cls = c; obs_bank = b; end
    checks++;
    if ({og[0], og[1], og[2], og[3], og[4]} !== {eg[0], eg[1], eg[2], eg[3], eg[4]}) begin
      failures++;
      $display("FAIL grant cyc=%0d got act=%b rd=%b wr=%b pre=%b ref=%b expected act=%b rd=%b wr=%b pre=%b ref=%b",
               cyc, og[0], og[1], og[2], og[3], og[4], eg[0], eg[1], eg[2], eg[3], eg[4]);
    end
    checks++;
    if ($countones({og[0], og[1], og[2], og[3], og[4]}) > 1) begin
      failures++;
      $display("FAIL grant_onehot cyc=%0d got %0d grant bits, expected at most 1",
               cyc, $countones({og[0], og[1], og[2], og[3], og[4]}));
    end
    checks++;
    if ({cmd_valid_o, cmd_type_o, cmd_ba_o, cmd_ra_o, cmd_ca_o, cmd_id_o, cmd_len_o} !==
        {e_valid, e_type, e_ba, e_ra, e_ca, e_id, e_len}) begin
      failures++;
      $display("FAIL cmd_reg cyc=%0d got v=%b t=%0d ba=%0d ra=%h ca=%h id=%h len=%h expected v=%b t=%0d ba=%0d ra=%h ca=%h id=%h len=%h",
               cyc, cmd_valid_o, cmd_type_o, cmd_ba_o, cmd_ra_o, cmd_ca_o, cmd_id_o, cmd_len_o,
               e_valid, e_type, e_ba, e_ra, e_ca, e_id, e_len);
    end
    if (rst) begin
      model_reset();
    end else if (wc >= 0) begin
      e_valid = 1'b1;
      e_type = 3'(wc);
      e_ba = BW'(wb);
      e_ra = (wc == 0) ? ra[wb*RA_W +: RA_W] : '0;
      e_ca = (wc == 1 || wc == 2) ? ca[wb*CA_W +: CA_W] : '0;
      e_id = (wc == 1 || wc == 2) ? id[wb*ID_W +: ID_W] : '0;
      e_len = (wc == 1 || wc == 2) ? len[wb*LEN_W +: LEN_W] : '0;
      ptr_m[wc] = (wb + 1) % N;
      if (wc == 0) begin last_act = cyc; act_times.push_back(cyc); end
      if (wc == 1) begin last_cas = cyc; last_rd = cyc; end
      if (wc == 2) begin last_cas = cyc; last_wr = cyc; end
    end else begin
      e_valid = 1'b0;
    end
    while (act_times.size() > 0 && cyc - act_times[0] > 64) void'(act_times.pop_front());
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
  endtask

  task automatic set_timing(int rrd, int ccd, int rtw, int wtr, int faw);
    t_rrd = TW'(rrd); t_ccd = TW'(ccd); t_rtw = TW'(rtw); t_wtr = TW'(wtr); t_faw = TW'(faw);
  endtask

  task automatic do_reset();
    clear_reqs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_timing(2, 2, 2, 2, 2);
    rst = 1'b1;
    act_req = '1; rd_req = '1; wr_req = '1; pre_req = '1; ref_req = '1;
    step();
    checks++;
    if (obs_cls !== -1) begin
      failures++; $display("FAIL reset_grant got class %0d bank %0d, expected none", obs_cls, obs_bank);
    end
    checks++;
    if ({cmd_valid_o, cmd_type_o, cmd_ba_o, cmd_ra_o} !== '0) begin
      failures++; $display("FAIL reset_cmd got v=%b t=%0d ba=%0d, expected all 0", cmd_valid_o, cmd_type_o, cmd_ba_o);
    end
    rst = 1'b0;
    clear_reqs();
    step();
  endtask

  task automatic test_act_rotation();
    set_timing(0, 0, 0, 0, 0);
    do_reset();
    act_req = '1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (obs_cls !== 0 || obs_bank !== k % N) begin
        failures++; $display("FAIL act_rotation step %0d got class %0d bank %0d, expected ACT bank %0d", k, obs_cls, obs_bank, k % N);
      end
      checks++;
      if (cmd_valid_o !== 1'b1 || cmd_ba_o !== BW'(k % N)) begin
        failures++; $display("FAIL act_rotation_ba step %0d got v=%b ba=%0d, expected v=1 ba=%0d", k, cmd_valid_o, cmd_ba_o, k % N);
      end
    end
    clear_reqs();
  endtask

  task automatic test_ccd();
    int n = 0;
    bit found = 0;
    set_timing(0, 3, 0, 0, 0);
    do_reset();
    rd_req = 4'b0100;
    step();
    checks++;
    if (obs_cls !== 1 || obs_bank !== 2) begin
      failures++; $display("FAIL ccd_first got class %0d bank %0d, expected RD bank 2", obs_cls, obs_bank);
    end
    rd_req = 4'b0010;
    for (int k = 0; k < 10 && !found; k++) begin
      step(); n++;
      if (obs_cls == 1) found = 1;
    end
    checks++;
    if (!found || n != 4 || obs_bank != 1) begin
      failures++; $display("FAIL ccd_gap got found=%0d after %0d cycles bank %0d, expected bank 1 after 4", found, n, obs_bank);
    end
    clear_reqs();
  endtask

  task automatic test_wtr_pre();
    int n = 0, gap_pre = 0;
    bit found = 0;
    set_timing(0, 0, 0, 5, 0);
    do_reset();
    wr_req = 4'b0001;
    step();
    checks++;
    if (obs_cls !== 2 || obs_bank !== 0) begin
      failures++; $display("FAIL wtr_wr got class %0d bank %0d, expected WR bank 0", obs_cls, obs_bank);
    end
    wr_req = '0; rd_req = 4'b0010; pre_req = 4'b1111;
    for (int k = 0; k < 12 && !found; k++) begin
      step(); n++;
      if (obs_cls == 1) found = 1;
      else if (obs_cls == 3) begin gap_pre++; pre_req[BW'(obs_bank)] = 1'b0; end
    end
    checks++;
    if (!found || n != 6) begin
      failures++; $display("FAIL wtr_gap got RD found=%0d after %0d cycles, expected after 6", found, n);
    end
    checks++;
    if (gap_pre != 4) begin
      failures++; $display("FAIL wtr_pre_fill got %0d PRE grants in gap, expected 4", gap_pre);
    end
    clear_reqs();
  endtask

  task automatic test_act_rd();
    int n = 0;
    bit found = 0;
    set_timing(3, 0, 0, 0, 0);
    do_reset();
    act_req = 4'b0001;
    step();
    act_req = 4'b0010; rd_req = 4'b0100;
    step();
    checks++;
    if (obs_cls !== 1 || obs_bank !== 2) begin
      failures++; $display("FAIL act_rd_bypass got class %0d bank %0d, expected RD bank 2", obs_cls, obs_bank);
    end
    rd_req = '0;
    for (int k = 0; k < 8 && !found; k++) begin
      step(); n++;
      if (obs_cls == 0) found = 1;
    end
    checks++;
    if (!found || n != 3 || obs_bank != 1) begin
      failures++; $display("FAIL act_rd_rrd got found=%0d after %0d cycles bank %0d, expected ACT bank 1 after 3", found, n, obs_bank);
    end
    clear_reqs();
  endtask

  task automatic test_reset_mid();
    set_timing(0, 0, 4, 0, 0);
    do_reset();
    rd_req = 4'b0001;
    step();
    rd_req = '0; act_req = '1; rst = 1'b1;
    step();
    checks++;
    if (obs_cls !== -1) begin
      failures++; $display("FAIL reset_mid_nogrant got class %0d bank %0d, expected none", obs_cls, obs_bank);
    end
    rst = 1'b0;
    step();
    checks++;
    if (obs_cls !== 0 || obs_bank !== 0) begin
      failures++; $display("FAIL reset_mid_act got class %0d bank %0d, expected ACT bank 0", obs_cls, obs_bank);
    end
    act_req = '0; wr_req = 4'b0001;
    step();
    checks++;
    if (obs_cls !== 2 || obs_bank !== 0) begin
      failures++; $display("FAIL reset_mid_rtw got class %0d bank %0d, expected WR bank 0", obs_cls, obs_bank);
    end
    clear_reqs();
  endtask

`ifdef SAL_SCHED_FAW_EN
  task automatic test_faw();
    int tm [6];
    int exp_t [6];
    int n_act = 0;
    exp_t = '{0, 1, 2, 3, 10, 11};
    set_timing(0, 0, 0, 0, 9);
    do_reset();
    act_req = '1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (obs_cls == 0 && n_act < 6) begin tm[n_act] = k; n_act++; end
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= n_act || tm[i] != exp_t[i]) begin
        failures++; $display("FAIL faw_act%0d got cycle %0d (count %0d), expected cycle %0d", i, (i < n_act) ? tm[i] : -1, n_act, exp_t[i]);
      end
    end
    clear_reqs();
  endtask
`endif

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      set_timing($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                 $urandom_range(0, 4), $urandom_range(0, 12));
      do_reset();
      for (int k = 0; k < 300; k++) begin
        act_req = N'($urandom) & N'($urandom);
        rd_req = N'($urandom) & N'($urandom);
        wr_req = N'($urandom) & N'($urandom);
        pre_req = N'($urandom) & N'($urandom) & N'($urandom);
        ref_req = N'($urandom) & N'($urandom) & N'($urandom);
        case (obs_cls)
          0: act_req[BW'(obs_bank)] = 1'b0;
          1: rd_req[BW'(obs_bank)] = 1'b0;
          2: wr_req[BW'(obs_bank)] = 1'b0;
          3: pre_req[BW'(obs_bank)] = 1'b0;
          4: ref_req[BW'(obs_bank)] = 1'b0;
          default: ;
        endcase
        rst = ($urandom_range(0, 99) == 0);
        step();
      end
      rst = 1'b0;
    end
    clear_reqs();
  endtask

  initial begin
    rst = 1'b1;
    clear_reqs();
    ra = '0; ca = '0; id = '0; len = '0;
    set_timing(0, 0, 0, 0, 0);
    cyc = 0; obs_cls = -1; obs_bank = -1;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_act_rotation();
    test_ccd();
    test_wtr_pre();
    test_act_rd();
    test_reset_mid();
`ifdef SAL_SCHED_FAW_EN
    test_faw();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
